// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : viterbi_pkg
// Purpose : Shared constants, scheduler state type and sizing helper for the
//           K=7, rate-1/2 Viterbi decoder BMC/ACS datapath.
// Contents: NSTATE  - trellis states (64)
//           NPAR    - parallel BMC/ACS lanes (8)
//           PM_W    - path-metric width in bits
//           sched_state_t - IDLE / RUN / DONE
//           grp_w() - width of the state-group counter
// Revision: 1.0 - initial release
// ============================================================================
package viterbi_pkg;

   localparam int NSTATE = 64;
   localparam int NPAR   = 8;
   localparam int PM_W   = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   // Group counter width; a single-group configuration still needs one bit.
   function automatic int grp_w(input int nstate, input int npar);
      int g;
      g = nstate / npar;
      return (g > 1) ? $clog2(g) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_acs_sched.sv
`default_nettype none
// ============================================================================
// Module  : viterbi_acs_sched
// Purpose : Sequencing controller for the time-multiplexed BMC/ACS datapath.
//           Accepts one symbol pair per trellis step, sweeps the state groups
//           through the NPAR lanes, and manages metric bank ping-pong,
//           normalization, initial seeding, survivor addressing and
//           traceback triggering.
// Ports   : clk, rst (async, active-high)     clock / reset
//           clr_i                              synchronous soft clear
//           sym_valid_i, sym_data_i, sym_ready_o   symbol handshake
//           tb_busy_i                          traceback engine busy
//           norm_flag_i                        OR of new-metric MSBs
//           acs_en_o, acs_sym_o, acs_grp_o     lane control
//           pm_rd_bank_o, acs_norm_o, pm_init_o    metric bank control
//           surv_we_o, surv_addr_o             survivor memory write port
//           step_done_o                        end-of-step pulse
//           tb_start_o, tb_ptr_o               traceback trigger
// Revision: 1.0 - initial release
// ============================================================================
module viterbi_acs_sched #(
   parameter  int NSTATE     = viterbi_pkg::NSTATE,
   parameter  int NPAR       = viterbi_pkg::NPAR,
   parameter  int SURV_DEPTH = 64,
   parameter  int TB_LEN     = 32,
   localparam int GRP_W      = viterbi_pkg::grp_w(NSTATE, NPAR),
   localparam int SP_W       = $clog2(SURV_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic                    sym_valid_i,
   input  logic [1:0]              sym_data_i,
   output logic                    sym_ready_o,
   input  logic                    tb_busy_i,
   input  logic                    norm_flag_i,
   output logic                    acs_en_o,
   output logic [1:0]              acs_sym_o,
   output logic [GRP_W-1:0]        acs_grp_o,
   output logic                    pm_rd_bank_o,
   output logic                    acs_norm_o,
   output logic                    pm_init_o,
   output logic                    surv_we_o,
   output logic [SP_W+GRP_W-1:0]   surv_addr_o,
   output logic                    step_done_o,
   output logic                    tb_start_o,
   output logic [SP_W-1:0]         tb_ptr_o
);

   import viterbi_pkg::*;

   localparam int                G        = NSTATE / NPAR;
   localparam int                TBC_W    = $clog2(TB_LEN + 1);
   localparam logic [GRP_W-1:0]  GRP_LAST = GRP_W'(G - 1);
   localparam logic [TBC_W-1:0]  TBC_LAST = TBC_W'(TB_LEN - 1);

   sched_state_t       state_q,      state_d;
   logic [GRP_W-1:0]   grp_q,        grp_d;
   logic [SP_W-1:0]    step_ptr_q,   step_ptr_d;
   logic [TBC_W-1:0]   tb_cnt_q,     tb_cnt_d;
   logic               nf_acc_q,     nf_acc_d;
   logic [1:0]         acs_sym_q,    acs_sym_d;
   logic               pm_rd_bank_q, pm_rd_bank_d;
   logic               acs_norm_q,   acs_norm_d;
   logic               pm_init_q,    pm_init_d;

   logic               in_idle;
   logic               in_run;
   logic               in_done;

   assign in_idle = (state_q == IDLE);
   assign in_run  = (state_q == RUN);
   assign in_done = (state_q == DONE);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grp_q        <= '0;
         step_ptr_q   <= '0;
         tb_cnt_q     <= '0;
         nf_acc_q     <= 1'b0;
         acs_sym_q    <= 2'b00;
         pm_rd_bank_q <= 1'b0;
         acs_norm_q   <= 1'b0;
         pm_init_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         grp_q        <= grp_d;
         step_ptr_q   <= step_ptr_d;
         tb_cnt_q     <= tb_cnt_d;
         nf_acc_q     <= nf_acc_d;
         acs_sym_q    <= acs_sym_d;
         pm_rd_bank_q <= pm_rd_bank_d;
         acs_norm_q   <= acs_norm_d;
         pm_init_q    <= pm_init_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      grp_d        = grp_q;
      step_ptr_d   = step_ptr_q;
      tb_cnt_d     = tb_cnt_q;
      nf_acc_d     = nf_acc_q;
      acs_sym_d    = acs_sym_q;
      pm_rd_bank_d = pm_rd_bank_q;
      acs_norm_d   = acs_norm_q;
      pm_init_d    = pm_init_q;

      case (state_q)
         IDLE: begin
            if (sym_valid_i && !tb_busy_i) begin
               acs_sym_d = sym_data_i;
               grp_d     = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            grp_d    = grp_q + GRP_W'(1);
            // The final RUN cycle's flag lands here too, before DONE reads it.
            nf_acc_d = nf_acc_q | norm_flag_i;
            if (grp_q == GRP_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            pm_rd_bank_d = ~pm_rd_bank_q;
            acs_norm_d   = nf_acc_q;
            nf_acc_d     = 1'b0;
            pm_init_d    = 1'b0;
            step_ptr_d   = step_ptr_q + SP_W'(1);
            tb_cnt_d     = (tb_cnt_q == TBC_LAST) ? '0 : tb_cnt_q + TBC_W'(1);
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Soft clear overrides everything, including an in-flight step.
      if (clr_i) begin
         state_d      = IDLE;
         grp_d        = '0;
         step_ptr_d   = '0;
         tb_cnt_d     = '0;
         nf_acc_d     = 1'b0;
         acs_sym_d    = 2'b00;
         pm_rd_bank_d = 1'b0;
         acs_norm_d   = 1'b0;
         pm_init_d    = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from registered state only (tb_busy_i gates ready)
   // ------------------------------------------------------------------------
   assign sym_ready_o  = in_idle & ~tb_busy_i;
   assign acs_en_o     = in_run;
   assign surv_we_o    = in_run;
   assign acs_sym_o    = acs_sym_q;
   assign acs_grp_o    = grp_q;
   assign pm_rd_bank_o = pm_rd_bank_q;
   assign acs_norm_o   = acs_norm_q;
   assign pm_init_o    = pm_init_q;
   assign surv_addr_o  = {step_ptr_q, grp_q};
   assign step_done_o  = in_done;
   // tb_cnt_q still holds the pre-increment count during DONE.
   assign tb_start_o   = in_done & (tb_cnt_q == TBC_LAST);
   assign tb_ptr_o     = step_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_acs_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_viterbi_acs_sched
// Purpose : Self-checking bench for viterbi_acs_sched. A step-level model
//           (steps completed since reset, flag raised in previous step)
//           predicts bank, seeding, normalization, survivor address and
//           traceback behaviour for randomized symbol streams.
// Revision: 1.0 - initial release
// ============================================================================
module tb_viterbi_acs_sched;

   localparam int G     = 8;
   localparam int GRP_W = 3;
   localparam int SP_W  = 6;
   localparam int DEPTH = 64;
   localparam int TBL   = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  clr;
   logic                  sym_valid;
   logic [1:0]            sym_data;
   logic                  sym_ready;
   logic                  tb_busy;
   logic                  norm_flag;
   logic                  acs_en;
   logic [1:0]            acs_sym;
   logic [GRP_W-1:0]      acs_grp;
   logic                  pm_rd_bank;
   logic                  acs_norm;
   logic                  pm_init;
   logic                  surv_we;
   logic [SP_W+GRP_W-1:0] surv_addr;
   logic                  step_done;
   logic                  tb_start;
   logic [SP_W-1:0]       tb_ptr;

   always #5 clk = ~clk;

   viterbi_acs_sched dut (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr),
      .sym_valid_i  (sym_valid),
      .sym_data_i   (sym_data),
      .sym_ready_o  (sym_ready),
      .tb_busy_i    (tb_busy),
      .norm_flag_i  (norm_flag),
      .acs_en_o     (acs_en),
      .acs_sym_o    (acs_sym),
      .acs_grp_o    (acs_grp),
      .pm_rd_bank_o (pm_rd_bank),
      .acs_norm_o   (acs_norm),
      .pm_init_o    (pm_init),
      .surv_we_o    (surv_we),
      .surv_addr_o  (surv_addr),
      .step_done_o  (step_done),
      .tb_start_o   (tb_start),
      .tb_ptr_o     (tb_ptr)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: steps completed since reset/clear, and whether any
   // normalization flag was raised during the previous step.
   int m_k;
   bit m_nf;

   // Per-cycle observations of one step; index 1..G is RUN, G+1 is DONE.
   logic                  en_s   [16];
   logic                  we_s   [16];
   logic [GRP_W-1:0]      grp_s  [16];
   logic [SP_W+GRP_W-1:0] addr_s [16];
   logic [1:0]            sym_s  [16];
   logic                  init_s [16];
   logic                  bank_s [16];
   logic                  norm_s [16];
   logic                  done_s [16];
   logic                  tbs_s  [16];
   logic [SP_W-1:0]       tbp_s  [16];
   logic                  rdy_s  [16];
   int                    s_wait;
   int                    s_acc;
   bit                    s_timeout;

   // Called at a negedge. Offers a symbol, waits for acceptance (bounded),
   // then records G+1 cycles. The producer keeps sym_valid high and keeps
   // changing sym_data during the step.
   task automatic drive_step(input logic [1:0] sym, input int nf_at, input int busy_at);
      s_wait    = 0;
      s_timeout = 0;
      sym_valid = 1'b1;
      sym_data  = sym;
      #1;
      while (sym_ready !== 1'b1) begin
         if (s_wait >= 200) begin
            s_timeout = 1;
            sym_valid = 1'b0;
            return;
         end
         s_wait++;
         @(negedge clk);
         #1;
      end
      s_acc = cyc;
      @(posedge clk);
      for (int c = 1; c <= G + 1; c++) begin
         @(negedge clk);
         en_s[c]   = acs_en;
         we_s[c]   = surv_we;
         grp_s[c]  = acs_grp;
         addr_s[c] = surv_addr;
         sym_s[c]  = acs_sym;
         init_s[c] = pm_init;
         bank_s[c] = pm_rd_bank;
         norm_s[c] = acs_norm;
         done_s[c] = step_done;
         tbs_s[c]  = tb_start;
         tbp_s[c]  = tb_ptr;
         rdy_s[c]  = sym_ready;
         sym_data  = 2'($urandom);
         norm_flag = (c == nf_at);
         if (busy_at != 0 && c == busy_at) tb_busy = 1'b1;
      end
      norm_flag = 1'b0;
      sym_valid = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_k  = 0;
      m_nf = 0;
   endtask

   task automatic test_reset();
      clr = 0; sym_valid = 0; sym_data = 0; tb_busy = 0; norm_flag = 0;
      rst = 1'b1;
      #1;
      total++; if ({acs_en, surv_we, step_done, tb_start} !== 4'b0000) begin bad++;
         $display("FAIL reset_strobes: got %b expected 0000", {acs_en, surv_we, step_done, tb_start}); end
      total++; if ({pm_init, pm_rd_bank, acs_norm} !== 3'b100) begin bad++;
         $display("FAIL reset_bank_ctrl: got %b expected 100", {pm_init, pm_rd_bank, acs_norm}); end
      total++; if (acs_sym !== 2'b00) begin bad++;
         $display("FAIL reset_acs_sym: got %b expected 00", acs_sym); end
      total++; if (surv_addr !== '0) begin bad++;
         $display("FAIL reset_surv_addr: got %0h expected 0", surv_addr); end
      total++; if (sym_ready !== 1'b1) begin bad++;
         $display("FAIL reset_ready: got %b expected 1", sym_ready); end
      @(negedge clk);
      tb_busy = 1'b1;
      #1;
      total++; if (sym_ready !== 1'b0) begin bad++;
         $display("FAIL reset_ready_busy: got %b expected 0", sym_ready); end
      @(negedge clk);
      tb_busy = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      total++; if ({sym_ready, acs_en, pm_init} !== 3'b101) begin bad++;
         $display("FAIL reset_released_idle: got %b expected 101", {sym_ready, acs_en, pm_init}); end
      m_k  = 0;
      m_nf = 0;
   endtask

   task automatic test_single();
      drive_step(2'b10, 0, 0);
      total++; if (s_timeout || s_wait != 0) begin bad++;
         $display("FAIL single_accept: timeout=%0d wait=%0d expected 0/0", s_timeout, s_wait); end
      for (int c = 1; c <= G; c++) begin
         total++; if ({en_s[c], we_s[c]} !== 2'b11 || grp_s[c] !== GRP_W'(c - 1)) begin bad++;
            $display("FAIL single_run c=%0d: en=%b we=%b grp=%0d expected 1 1 %0d", c, en_s[c], we_s[c], grp_s[c], c - 1); end
         total++; if ({sym_s[c], init_s[c], bank_s[c], done_s[c], rdy_s[c]} !== 6'b10_1000) begin bad++;
            $display("FAIL single_ctrl c=%0d: got %b expected 101000", c, {sym_s[c], init_s[c], bank_s[c], done_s[c], rdy_s[c]}); end
      end
      total++; if ({en_s[G+1], done_s[G+1], tbs_s[G+1]} !== 3'b010) begin bad++;
         $display("FAIL single_done: got %b expected 010", {en_s[G+1], done_s[G+1], tbs_s[G+1]}); end
      @(negedge clk);
      total++; if ({pm_rd_bank, pm_init, sym_ready, acs_en} !== 4'b1010) begin bad++;
         $display("FAIL single_after: got %b expected 1010", {pm_rd_bank, pm_init, sym_ready, acs_en}); end
      m_k  = 1;
      m_nf = 0;
   endtask

   task automatic test_back_to_back();
      int tb_count;
      int prev_acc;
      apply_reset();
      tb_count = 0;
      prev_acc = 0;
      for (int s = 0; s < 40; s++) begin
         logic [1:0] sym;
         int         nf_at;
         bit         exp_en;
         sym   = 2'($urandom);
         nf_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, G)) : 0;
         drive_step(sym, nf_at, 0);
         total++; if (s_timeout || (s > 0 && s_acc - prev_acc != G + 2)) begin bad++;
            $display("FAIL b2b_accept s=%0d: timeout=%0d gap=%0d expected %0d", s, s_timeout, s_acc - prev_acc, G + 2); end
         prev_acc = s_acc;
         for (int c = 1; c <= G + 1; c++) begin
            exp_en = (c <= G);
            total++; if (en_s[c] !== exp_en || we_s[c] !== exp_en) begin bad++;
               $display("FAIL b2b_en s=%0d c=%0d: en=%b we=%b expected %b", s, c, en_s[c], we_s[c], exp_en); end
            if (c <= G) begin
               total++; if (addr_s[c] !== {SP_W'(m_k % DEPTH), GRP_W'(c - 1)} || grp_s[c] !== GRP_W'(c - 1)) begin bad++;
                  $display("FAIL b2b_addr s=%0d c=%0d: addr=%0h grp=%0d expected ptr %0d grp %0d", s, c, addr_s[c], grp_s[c], m_k % DEPTH, c - 1); end
               total++; if ({sym_s[c], init_s[c], bank_s[c], norm_s[c]} !== {sym, m_k == 0, m_k % 2 == 1, m_nf}) begin bad++;
                  $display("FAIL b2b_ctrl s=%0d c=%0d: got %b expected %b", s, c, {sym_s[c], init_s[c], bank_s[c], norm_s[c]}, {sym, m_k == 0, m_k % 2 == 1, m_nf}); end
            end
            total++; if (done_s[c] !== (c == G + 1) || rdy_s[c] !== 1'b0) begin bad++;
               $display("FAIL b2b_done s=%0d c=%0d: done=%b ready=%b expected %b 0", s, c, done_s[c], rdy_s[c], c == G + 1); end
            total++; if (tbs_s[c] !== (c == G + 1 && (m_k + 1) % TBL == 0)) begin bad++;
               $display("FAIL b2b_tb_start s=%0d c=%0d: got %b expected %b", s, c, tbs_s[c], c == G + 1 && (m_k + 1) % TBL == 0); end
         end
         if (tbs_s[G+1] === 1'b1) begin
            tb_count++;
            total++; if (tbp_s[G+1] !== SP_W'(m_k % DEPTH)) begin bad++;
               $display("FAIL b2b_tb_ptr: got %0d expected %0d", tbp_s[G+1], m_k % DEPTH); end
         end
         m_nf = (nf_at != 0);
         m_k++;
      end
      total++; if (tb_count != 1) begin bad++;
         $display("FAIL b2b_tb_count: got %0d expected 1", tb_count); end
   endtask

   // Continues the stream of test_back_to_back through the pointer wrap.
   task automatic test_wrap();
      int tb_count;
      tb_count = 0;
      for (int s = 0; s < 30; s++) begin
         int nf_at;
         nf_at = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, G)) : 0;
         drive_step(2'($urandom), nf_at, 0);
         total++; if (s_timeout) begin bad++;
            $display("FAIL wrap_accept: timeout at step %0d", m_k); end
         total++; if (addr_s[1] !== {SP_W'(m_k % DEPTH), GRP_W'(0)} || addr_s[G] !== {SP_W'(m_k % DEPTH), GRP_W'(G - 1)}) begin bad++;
            $display("FAIL wrap_addr step=%0d: first=%0h last=%0h expected ptr %0d", m_k, addr_s[1], addr_s[G], m_k % DEPTH); end
         total++; if (norm_s[1] !== m_nf || bank_s[1] !== (m_k % 2 == 1)) begin bad++;
            $display("FAIL wrap_ctrl step=%0d: norm=%b bank=%b expected %b %b", m_k, norm_s[1], bank_s[1], m_nf, m_k % 2 == 1); end
         total++; if (tbs_s[G+1] !== ((m_k + 1) % TBL == 0)) begin bad++;
            $display("FAIL wrap_tb_start step=%0d: got %b expected %b", m_k, tbs_s[G+1], (m_k + 1) % TBL == 0); end
         if (tbs_s[G+1] === 1'b1) begin
            tb_count++;
            total++; if (tbp_s[G+1] !== SP_W'(m_k % DEPTH)) begin bad++;
               $display("FAIL wrap_tb_ptr: got %0d expected %0d", tbp_s[G+1], m_k % DEPTH); end
         end
         m_nf = (nf_at != 0);
         m_k++;
      end
      total++; if (tb_count != 1) begin bad++;
         $display("FAIL wrap_tb_count: got %0d expected 1", tb_count); end
   endtask

   task automatic test_norm();
      int nf_tab  [4] = '{G, 7, 0, 0};
      bit exp_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      apply_reset();
      for (int s = 0; s < 4; s++) begin
         drive_step(2'($urandom), nf_tab[s], 0);
         for (int c = 1; c <= G; c++) begin
            total++; if (norm_s[c] !== exp_tab[s]) begin bad++;
               $display("FAIL norm step=%0d c=%0d: got %b expected %b", s, c, norm_s[c], exp_tab[s]); end
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      tb_busy   = 1'b1;
      sym_valid = 1'b1;
      sym_data  = 2'b01;
      repeat (5) begin
         @(negedge clk);
         total++; if ({sym_ready, acs_en} !== 2'b00) begin bad++;
            $display("FAIL bp_idle_busy: ready/en got %b expected 00", {sym_ready, acs_en}); end
      end
      tb_busy = 1'b0;
      drive_step(2'b01, 0, 4);
      total++; if (s_timeout || s_wait != 0) begin bad++;
         $display("FAIL bp_accept: timeout=%0d wait=%0d expected 0/0", s_timeout, s_wait); end
      for (int c = 1; c <= G; c++) begin
         total++; if (en_s[c] !== 1'b1) begin bad++;
            $display("FAIL bp_run c=%0d: en got %b expected 1", c, en_s[c]); end
      end
      total++; if (done_s[G+1] !== 1'b1) begin bad++;
         $display("FAIL bp_done: got %b expected 1", done_s[G+1]); end
      sym_valid = 1'b1;
      sym_data  = 2'b11;
      repeat (6) begin
         @(negedge clk);
         total++; if ({sym_ready, acs_en} !== 2'b00) begin bad++;
            $display("FAIL bp_hold: ready/en got %b expected 00", {sym_ready, acs_en}); end
      end
      tb_busy = 1'b0;
      #1;
      total++; if (sym_ready !== 1'b1) begin bad++;
         $display("FAIL bp_release_ready: got %b expected 1", sym_ready); end
      @(negedge clk);
      sym_valid = 1'b0;
      total++; if ({acs_en, acs_sym} !== 3'b111) begin bad++;
         $display("FAIL bp_release_accept: en/sym got %b expected 111", {acs_en, acs_sym}); end
      repeat (G + 2) @(negedge clk);
   endtask

   task automatic test_abort();
      apply_reset();
      drive_step(2'b11, 3, 0);
      sym_valid = 1'b1;
      sym_data  = 2'b01;
      @(negedge clk);
      @(posedge clk);
      #1 sym_valid = 1'b0;
      repeat (4) @(negedge clk);
      total++; if ({acs_en, acs_sym, pm_rd_bank, acs_norm, pm_init} !== 6'b101110) begin bad++;
         $display("FAIL abort_pre: got %b expected 101110", {acs_en, acs_sym, pm_rd_bank, acs_norm, pm_init}); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      total++; if ({acs_en, surv_we, step_done, tb_start, sym_ready} !== 5'b00001) begin bad++;
         $display("FAIL abort_strobes: got %b expected 00001", {acs_en, surv_we, step_done, tb_start, sym_ready}); end
      total++; if ({acs_sym, pm_rd_bank, acs_norm, pm_init} !== 5'b00001 || surv_addr !== '0) begin bad++;
         $display("FAIL abort_regs: ctrl=%b addr=%0h expected 00001 0", {acs_sym, pm_rd_bank, acs_norm, pm_init}, surv_addr); end
      repeat (12) begin
         @(negedge clk);
         total++; if ({step_done, acs_en} !== 2'b00) begin bad++;
            $display("FAIL abort_quiet: done/en got %b expected 00", {step_done, acs_en}); end
      end
      drive_step(2'b10, 2, 0);
      total++; if (addr_s[1] !== '0 || {init_s[1], bank_s[1], norm_s[1]} !== 3'b100) begin bad++;
         $display("FAIL abort_restart: addr=%0h ctrl=%b expected 0 100", addr_s[1], {init_s[1], bank_s[1], norm_s[1]}); end
      sym_valid = 1'b1;
      sym_data  = 2'b01;
      @(negedge clk);
      @(posedge clk);
      #1 sym_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++; if ({acs_en, step_done, acs_sym, pm_rd_bank, acs_norm, pm_init} !== 7'b0000001 || surv_addr !== '0) begin bad++;
         $display("FAIL async_rst: ctrl=%b addr=%0h expected 0000001 0", {acs_en, step_done, acs_sym, pm_rd_bank, acs_norm, pm_init}, surv_addr); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_norm();
      test_backpressure();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
